obstacle_edge_sequencer: RTL and testbench
==========================================

# obstacle_edge_sequencer

Walks the obstacle polygons currently on screen and streams every polygon edge, one per handshake, to the collision/physics stage. It sits directly downstream of the on-screen obstacle gatherer. It snapshots that block's obstacle arrays on `start_in`, then iterates obstacle by obstacle and edge by edge, including the closing edge from the last vertex back to vertex 0.

## Interface
- `WORLD_BITS`, 32: width of one packed vertex word; x = signed `[WORLD_BITS-1:WORLD_BITS/2]`, y = signed `[WORLD_BITS/2-1:0]`.
- `MAX_NUM_VERTICES`, 8: vertex slots per obstacle.
- `MAX_OBSTACLES_ON_SCREEN`, 16: obstacle slots.
- `clk_in`  in  1  single system clock.
- `rst_in`  in  1  reset, asynchronous, active-low.
- `start_in`  in  1  one-cycle pulse; snapshot inputs and begin a scan; ignored while `busy_out`.
- `obstacles_in`  in  signed `[WORLD_BITS-1:0]` `[MAX_OBSTACLES_ON_SCREEN][MAX_NUM_VERTICES]`  packed vertices.
- `obstacles_num_sides_in`  in  `$clog2(MAX_NUM_VERTICES+1)` per obstacle  vertex count.
- `num_obstacles_in`  in  `$clog2(MAX_OBSTACLES_ON_SCREEN+1)`  valid obstacle count.
- `query_min_x_in`, `query_max_x_in`, `query_min_y_in`, `query_max_y_in`  in  signed `WORLD_BITS/2` each  cull rectangle; present only with the macro.
- `edge_ready_in`  in  1  consumer accepts the edge.
- `edge_valid_out`  out  1  edge fields are valid.
- `edge_x0_out`, `edge_y0_out`, `edge_x1_out`, `edge_y1_out`  out  signed `WORLD_BITS/2`  edge endpoints.
- `edge_obstacle_idx_out`  out  `$clog2(MAX_OBSTACLES_ON_SCREEN)`  source obstacle index.
- `busy_out`  out  1  scan in progress.
- `done_out`  out  1  one-cycle pulse at scan end.

## Operation
- **FSM states:** IDLE, SCAN, DONE.
- **IDLE → SCAN:** on `start_in`. The block registers all array inputs and counts into a snapshot. Upstream may change its outputs afterwards.
- **Count clamping:**
  - `num_obstacles` is clamped to `MAX_OBSTACLES_ON_SCREEN`.
  - Each side count is clamped to `MAX_NUM_VERTICES`.
- **Edges per obstacle with n vertices:**
  - n ≥ 3: n edges, (v[i], v[i+1]) for i < n−1, then (v[n−1], v[0]).
  - n = 2: one edge, (v0, v1).
  - n ≤ 1: no edges; the obstacle is skipped in one cycle.
- **Order:** obstacle index ascending, then edge index ascending.
- **Handshake:** a transfer occurs when `edge_valid_out && edge_ready_in`. While valid and not ready, all edge outputs hold stable. Once asserted, valid never drops without a transfer.
- **SCAN → DONE:** when the iterator passes the last edge of the last obstacle and no edge is pending.
- **DONE:** `done_out` = 1 for one cycle; next state IDLE.
- **Zero obstacles:** SCAN lasts one cycle, then DONE. No edges are emitted.
- **Reset:** asynchronous and effective mid-scan. The FSM returns to IDLE, the pending edge is dropped, and no `done_out` is produced.
- **Reset values:** `edge_valid_out`=0, `busy_out`=0, `done_out`=0, all edge fields 0, `edge_obstacle_idx_out`=0.

## Timing
- `start_in` sampled at edge k:
  - `busy_out`=1 from k.
  - First `edge_valid_out` from edge k+1, provided it is not skipped or culled.
- **Throughput:** one edge per cycle with `edge_ready_in` held high. The output register refills in the same cycle as a transfer.
- **Cycle cost:** each skipped obstacle or culled edge costs one cycle with valid low.
- **End of scan:** `done_out` is asserted in the cycle after the final transfer. `busy_out` drops in the same cycle that `done_out` is high.
- `start_in` while busy is ignored, with no queueing.

## Configuration
- **`EDGE_BBOX_CULL_EN` defined:**
  - The query ports exist.
  - An edge is emitted only if its axis-aligned bounding box overlaps the query rectangle, inclusive on all bounds.
  - Culled edges are dropped silently.
- **Undefined:** the query ports are absent and every edge is emitted.

## Structure
- **Package `obstacle_pkg`:**
  - `vertex_t` packed {x, y}.
  - `edge_t` struct (x0, y0, x1, y1, obstacle index).
  - Unpack functions `vertex_x` / `vertex_y`.
  - Width localparams derived from the three parameters.
- **Sub-module `obstacle_edge_iterator`:** holds the obstacle and edge counters with wrap-around to vertex 0. It produces current and next vertex indices plus the `last` and `skip` flags.

## Test plan
- **Triangle:** one obstacle (0,0),(10,0),(0,10); ready held high → edges (0,0→10,0), (10,0→0,10), (0,10→0,0) on cycles k+1..k+3, `done_out` at k+4.
- **Backpressure:** same triangle; `edge_ready_in` low for 5 cycles at the second edge → fields stable for 5 cycles, total 3 transfers, no duplicates.
- **Degenerate mix:** obstacles with n = 0, 1, 2, 4 → exactly 0+0+1+4 = 5 edges; index field reads 2, 3, 3, 3, 3.
- **Clamping:** `num_obstacles_in`=0 → `done_out` at k+2 with no valid. Side count 9 with `MAX_NUM_VERTICES`=8 → 8 edges.
- **Reset mid-scan:** `rst_in` low during the second edge → valid, busy and done all 0 immediately. The next `start_in` restarts at edge 0.
- **Culling (macro on):** query x 20..30, y 0..5; square (0,0)-(25,25) → only the bottom (0,0→25,0) and right (25,0→25,25) edges are emitted.

Source files
------------

// File: rtl/obstacle_edge_sequencer_pkg.sv
// Shared widths, packed vertex/edge types and helpers for the obstacle edge sequencer.
// A vertex word carries signed x in its upper half and signed y in its lower half.
package obstacle_pkg;

    localparam int WORLD_BITS              = 32;
    localparam int MAX_NUM_VERTICES        = 8;
    localparam int MAX_OBSTACLES_ON_SCREEN = 16;

    localparam int COORD_W   = WORLD_BITS / 2;
    localparam int SIDES_W   = $clog2(MAX_NUM_VERTICES + 1);
    localparam int NUM_W     = $clog2(MAX_OBSTACLES_ON_SCREEN + 1);
    localparam int OBS_IDX_W = $clog2(MAX_OBSTACLES_ON_SCREEN);
    localparam int VTX_IDX_W = $clog2(MAX_NUM_VERTICES);

    typedef logic signed [COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } vertex_t;

    typedef struct packed {
        coord_t                 x0;
        coord_t                 y0;
        coord_t                 x1;
        coord_t                 y1;
        logic [OBS_IDX_W-1:0]   obstacle_idx;
    } edge_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } seq_state_t;

    function automatic coord_t vertex_x(input logic [WORLD_BITS-1:0] v);
        vertex_t t;
        t = vertex_t'(v);
        return t.x;
    endfunction

    function automatic coord_t vertex_y(input logic [WORLD_BITS-1:0] v);
        vertex_t t;
        t = vertex_t'(v);
        return t.y;
    endfunction

    function automatic logic [SIDES_W-1:0] clamp_sides(input logic [SIDES_W-1:0] n);
        return (n > SIDES_W'(MAX_NUM_VERTICES)) ? SIDES_W'(MAX_NUM_VERTICES) : n;
    endfunction

    function automatic logic [NUM_W-1:0] clamp_num(input logic [NUM_W-1:0] n);
        return (n > NUM_W'(MAX_OBSTACLES_ON_SCREEN)) ? NUM_W'(MAX_OBSTACLES_ON_SCREEN) : n;
    endfunction

endpackage

// File: rtl/obstacle_edge_sequencer_if.sv
// Edge stream from the obstacle edge sequencer to the collision/physics stage.
// A transfer happens on edge_valid_out && edge_ready_in.
interface obstacle_edge_sequencer_if;
    import obstacle_pkg::*;

    logic                 edge_valid_out;
    logic                 edge_ready_in;
    coord_t               edge_x0_out;
    coord_t               edge_y0_out;
    coord_t               edge_x1_out;
    coord_t               edge_y1_out;
    logic [OBS_IDX_W-1:0] edge_obstacle_idx_out;

    modport master (
        output edge_valid_out,
        output edge_x0_out,
        output edge_y0_out,
        output edge_x1_out,
        output edge_y1_out,
        output edge_obstacle_idx_out,
        input  edge_ready_in
    );

    modport slave (
        input  edge_valid_out,
        input  edge_x0_out,
        input  edge_y0_out,
        input  edge_x1_out,
        input  edge_y1_out,
        input  edge_obstacle_idx_out,
        output edge_ready_in
    );
endinterface

// File: rtl/obstacle_edge_iterator.sv
// Obstacle/edge counters: current and next vertex index with wrap to vertex 0, plus end flags.
// Latency: flags are combinational from the counters; one step per advance pulse.
// Backpressure: the caller withholds advance while its output register is full.
module obstacle_edge_iterator
    import obstacle_pkg::*;
(
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 clear,
    input  logic                 advance,
    input  logic [NUM_W-1:0]     num_obstacles,
    input  logic [SIDES_W-1:0]   num_sides [MAX_OBSTACLES_ON_SCREEN],
    output logic [OBS_IDX_W-1:0] obs_idx,
    output logic [VTX_IDX_W-1:0] cur_vtx,
    output logic [VTX_IDX_W-1:0] nxt_vtx,
    output logic                 last,
    output logic                 skip,
    output logic                 last_obs
);
    logic [NUM_W-1:0]     obs_cnt;
    logic [VTX_IDX_W-1:0] edge_cnt;
    logic [SIDES_W-1:0]   n;
    logic                 in_range;
    logic                 at_wrap;

    assign obs_idx  = obs_cnt[OBS_IDX_W-1:0];
    assign in_range = obs_cnt < num_obstacles;
    assign n        = num_sides[obs_idx];
    assign at_wrap  = SIDES_W'(edge_cnt) == (n - SIDES_W'(1));

    // A two-vertex obstacle is a single segment, so its one edge is also its last.
    assign skip     = !in_range || (n < SIDES_W'(2));
    assign last     = (n == SIDES_W'(2)) || at_wrap;
    assign last_obs = (obs_cnt + NUM_W'(1)) >= num_obstacles;
    assign cur_vtx  = edge_cnt;
    assign nxt_vtx  = at_wrap ? '0 : edge_cnt + VTX_IDX_W'(1);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            obs_cnt  <= '0;
            edge_cnt <= '0;
        end else if (clear) begin
            obs_cnt  <= '0;
            edge_cnt <= '0;
        end else if (advance) begin
            if (skip || last) begin
                obs_cnt  <= obs_cnt + NUM_W'(1);
                edge_cnt <= '0;
            end else begin
                edge_cnt <= edge_cnt + VTX_IDX_W'(1);
            end
        end
    end
endmodule

// File: rtl/obstacle_edge_sequencer.sv
// Snapshots on-screen obstacles on start and streams every polygon edge (incl. closing edge).
// Latency: first edge valid one cycle after start; one edge per cycle with ready held high.
// Backpressure: valid/ready, output held until taken; EDGE_BBOX_CULL_EN adds query-rect culling.
module obstacle_edge_sequencer
    import obstacle_pkg::*;
(
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         start_in,
    input  logic signed [WORLD_BITS-1:0] obstacles_in [MAX_OBSTACLES_ON_SCREEN][MAX_NUM_VERTICES],
    input  logic [SIDES_W-1:0]           obstacles_num_sides_in [MAX_OBSTACLES_ON_SCREEN],
    input  logic [NUM_W-1:0]             num_obstacles_in,
`ifdef EDGE_BBOX_CULL_EN
    input  coord_t                       query_min_x_in,
    input  coord_t                       query_max_x_in,
    input  coord_t                       query_min_y_in,
    input  coord_t                       query_max_y_in,
`endif
    obstacle_edge_sequencer_if.master    edge_if,
    output logic                         busy_out,
    output logic                         done_out
);
    logic [WORLD_BITS-1:0] snap_vtx [MAX_OBSTACLES_ON_SCREEN][MAX_NUM_VERTICES];
    logic [SIDES_W-1:0]    snap_sides [MAX_OBSTACLES_ON_SCREEN];
    logic [NUM_W-1:0]      snap_num;

    seq_state_t            state;
    logic                  scan_end;
    logic                  start_ok;
    logic                  can_load;
    logic                  advance;
    logic                  hit;
    logic                  emit;

    logic [OBS_IDX_W-1:0]  it_obs;
    logic [VTX_IDX_W-1:0]  it_cur;
    logic [VTX_IDX_W-1:0]  it_nxt;
    logic                  it_last;
    logic                  it_skip;
    logic                  it_last_obs;

    logic [WORLD_BITS-1:0] v0_w;
    logic [WORLD_BITS-1:0] v1_w;
    coord_t                ex0, ey0, ex1, ey1;

    assign start_ok = (state == ST_IDLE) && start_in;
    assign can_load = !edge_if.edge_valid_out || edge_if.edge_ready_in;
    assign advance  = (state == ST_SCAN) && can_load && !scan_end;

    always_ff @(posedge clk_in) begin
        if (start_ok) begin
            snap_num <= clamp_num(num_obstacles_in);
            for (int i = 0; i < MAX_OBSTACLES_ON_SCREEN; i++) begin
                snap_sides[i] <= clamp_sides(obstacles_num_sides_in[i]);
                for (int j = 0; j < MAX_NUM_VERTICES; j++) begin
                    snap_vtx[i][j] <= obstacles_in[i][j];
                end
            end
        end
    end

    obstacle_edge_iterator u_iter (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .clear         (start_ok),
        .advance       (advance),
        .num_obstacles (snap_num),
        .num_sides     (snap_sides),
        .obs_idx       (it_obs),
        .cur_vtx       (it_cur),
        .nxt_vtx       (it_nxt),
        .last          (it_last),
        .skip          (it_skip),
        .last_obs      (it_last_obs)
    );

    assign v0_w = snap_vtx[it_obs][it_cur];
    assign v1_w = snap_vtx[it_obs][it_nxt];
    assign ex0  = vertex_x(v0_w);
    assign ey0  = vertex_y(v0_w);
    assign ex1  = vertex_x(v1_w);
    assign ey1  = vertex_y(v1_w);

`ifdef EDGE_BBOX_CULL_EN
    coord_t bb_min_x, bb_max_x, bb_min_y, bb_max_y;

    assign bb_min_x = (ex0 < ex1) ? ex0 : ex1;
    assign bb_max_x = (ex0 < ex1) ? ex1 : ex0;
    assign bb_min_y = (ey0 < ey1) ? ey0 : ey1;
    assign bb_max_y = (ey0 < ey1) ? ey1 : ey0;
    assign hit = (bb_min_x <= query_max_x_in) && (bb_max_x >= query_min_x_in) &&
                 (bb_min_y <= query_max_y_in) && (bb_max_y >= query_min_y_in);
`else
    assign hit = 1'b1;
`endif

    assign emit = !it_skip && hit;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state                         <= ST_IDLE;
            scan_end                      <= 1'b0;
            busy_out                      <= 1'b0;
            done_out                      <= 1'b0;
            edge_if.edge_valid_out        <= 1'b0;
            edge_if.edge_x0_out           <= '0;
            edge_if.edge_y0_out           <= '0;
            edge_if.edge_x1_out           <= '0;
            edge_if.edge_y1_out           <= '0;
            edge_if.edge_obstacle_idx_out <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_in) begin
                        state    <= ST_SCAN;
                        busy_out <= 1'b1;
                        scan_end <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (can_load) begin
                        if (scan_end) begin
                            state                  <= ST_DONE;
                            busy_out               <= 1'b0;
                            done_out               <= 1'b1;
                            edge_if.edge_valid_out <= 1'b0;
                        end else begin
                            // Skipped obstacles and culled edges still step the iterator, costing one idle cycle.
                            if ((it_skip || it_last) && it_last_obs) begin
                                scan_end <= 1'b1;
                            end
                            edge_if.edge_valid_out <= emit;
                            if (emit) begin
                                edge_if.edge_x0_out           <= ex0;
                                edge_if.edge_y0_out           <= ey0;
                                edge_if.edge_x1_out           <= ex1;
                                edge_if.edge_y1_out           <= ey1;
                                edge_if.edge_obstacle_idx_out <= it_obs;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    done_out <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_obstacle_edge_sequencer.sv
// Directed bench for obstacle_edge_sequencer: table of scan scenarios plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_obstacle_edge_sequencer;
    import obstacle_pkg::*;

    logic                         clk_in = 1'b0;
    logic                         rst_in;
    logic                         start_in;
    logic signed [WORLD_BITS-1:0] obstacles_in [MAX_OBSTACLES_ON_SCREEN][MAX_NUM_VERTICES];
    logic [SIDES_W-1:0]           obstacles_num_sides_in [MAX_OBSTACLES_ON_SCREEN];
    logic [NUM_W-1:0]             num_obstacles_in;
    logic                         busy_out;
    logic                         done_out;
`ifdef EDGE_BBOX_CULL_EN
    coord_t query_min_x_in, query_max_x_in, query_min_y_in, query_max_y_in;
`endif

    obstacle_edge_sequencer_if eif();

    always #5 clk_in = ~clk_in;

    obstacle_edge_sequencer dut (
        .clk_in                 (clk_in),
        .rst_in                 (rst_in),
        .start_in               (start_in),
        .obstacles_in           (obstacles_in),
        .obstacles_num_sides_in (obstacles_num_sides_in),
        .num_obstacles_in       (num_obstacles_in),
`ifdef EDGE_BBOX_CULL_EN
        .query_min_x_in         (query_min_x_in),
        .query_max_x_in         (query_max_x_in),
        .query_min_y_in         (query_min_y_in),
        .query_max_y_in         (query_max_y_in),
`endif
        .edge_if                (eif),
        .busy_out               (busy_out),
        .done_out               (done_out)
    );

    typedef struct {
        int num;
        int s0, s1, s2, s3;
        int exp_edges;
        int exp_first;
        int exp_done;
        int poke;
    } scan_vec_t;

    int    errors = 0;
    int    checks = 0;
    edge_t exp_q[$];

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_edge(input string name, input edge_t act, input edge_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got (%0d,%0d)->(%0d,%0d) idx %0d expected (%0d,%0d)->(%0d,%0d) idx %0d",
                     name, act.x0, act.y0, act.x1, act.y1, act.obstacle_idx,
                     exp.x0, exp.y0, exp.x1, exp.y1, exp.obstacle_idx);
        end
    endtask

    function automatic logic [WORLD_BITS-1:0] pack_v(input int x, input int y);
        logic [15:0] xs, ys;
        xs = x[15:0];
        ys = y[15:0];
        return {xs, ys};
    endfunction

    function automatic edge_t mk_edge(input int x0, input int y0, input int x1, input int y1, input int idx);
        edge_t e;
        e.x0 = 16'(x0);
        e.y0 = 16'(y0);
        e.x1 = 16'(x1);
        e.y1 = 16'(y1);
        e.obstacle_idx = idx[OBS_IDX_W-1:0];
        return e;
    endfunction

    function automatic edge_t dut_edge();
        edge_t e;
        e.x0 = eif.edge_x0_out;
        e.y0 = eif.edge_y0_out;
        e.x1 = eif.edge_x1_out;
        e.y1 = eif.edge_y1_out;
        e.obstacle_idx = eif.edge_obstacle_idx_out;
        return e;
    endfunction

    task automatic set_pattern(input scan_vec_t v);
        for (int i = 0; i < MAX_OBSTACLES_ON_SCREEN; i++) begin
            obstacles_num_sides_in[i] = '0;
            for (int j = 0; j < MAX_NUM_VERTICES; j++)
                obstacles_in[i][j] = pack_v(i * 16 + j, -(i * 8 + j));
        end
        obstacles_num_sides_in[0] = v.s0[SIDES_W-1:0];
        obstacles_num_sides_in[1] = v.s1[SIDES_W-1:0];
        obstacles_num_sides_in[2] = v.s2[SIDES_W-1:0];
        obstacles_num_sides_in[3] = v.s3[SIDES_W-1:0];
        num_obstacles_in = v.num[NUM_W-1:0];
    endtask

    // Reference enumeration of the expected edge list from the bench's own input arrays.
    task automatic build_expected(input int num);
        int nobs, n, ne, j1;
        logic [WORLD_BITS-1:0] v0, v1;
        exp_q.delete();
        nobs = (num > MAX_OBSTACLES_ON_SCREEN) ? MAX_OBSTACLES_ON_SCREEN : num;
        for (int i = 0; i < nobs; i++) begin
            n = int'(obstacles_num_sides_in[i]);
            if (n > MAX_NUM_VERTICES) n = MAX_NUM_VERTICES;
            if (n >= 2) begin
                ne = (n == 2) ? 1 : n;
                for (int e = 0; e < ne; e++) begin
                    j1 = (e == n - 1) ? 0 : e + 1;
                    v0 = obstacles_in[i][e];
                    v1 = obstacles_in[i][j1];
                    exp_q.push_back(mk_edge(int'(signed'(v0[31:16])), int'(signed'(v0[15:0])),
                                            int'(signed'(v1[31:16])), int'(signed'(v1[15:0])), i));
                end
            end
        end
    endtask

    task automatic load_triangle();
        for (int i = 0; i < MAX_OBSTACLES_ON_SCREEN; i++) obstacles_num_sides_in[i] = '0;
        obstacles_in[0][0] = pack_v(0, 0);
        obstacles_in[0][1] = pack_v(10, 0);
        obstacles_in[0][2] = pack_v(0, 10);
        obstacles_num_sides_in[0] = 4'd3;
        num_obstacles_in = 5'd1;
        exp_q.delete();
        exp_q.push_back(mk_edge(0, 0, 10, 0, 0));
        exp_q.push_back(mk_edge(10, 0, 0, 10, 0));
        exp_q.push_back(mk_edge(0, 10, 0, 0, 0));
    endtask

    task automatic pulse_start();
        @(negedge clk_in);
        start_in = 1'b1;
        @(posedge clk_in);
        #1 start_in = 1'b0;
    endtask

    // Ready held high; cycle 0 is the cycle right after the start edge. poke >= 0 re-pulses start while busy.
    task automatic run_scan(input string name, input int exp_edges, input int exp_first,
                            input int exp_done, input int poke);
        int got, first, done_cyc;
        bit seen_done;
        got = 0; first = -1; done_cyc = -1; seen_done = 1'b0;
        eif.edge_ready_in = 1'b1;
        pulse_start();
        for (int c = 0; c < 200 && !seen_done; c++) begin
            @(negedge clk_in);
            if (c == 0) check({name, "_busy_k"}, busy_out, 1);
            if (eif.edge_valid_out) begin
                if (first < 0) first = c;
                if (got < exp_q.size()) check_edge($sformatf("%s_edge%0d", name, got), dut_edge(), exp_q[got]);
                got++;
            end
            if (done_out) begin
                seen_done = 1'b1;
                done_cyc  = c;
                check({name, "_busy_at_done"}, busy_out, 0);
            end
            start_in = (c == poke);
        end
        start_in = 1'b0;
        check({name, "_done_seen"}, seen_done, 1);
        check({name, "_done_cycle"}, done_cyc, exp_done);
        check({name, "_edge_count"}, got, exp_edges);
        check({name, "_first_valid"}, first, exp_first);
    endtask

    scan_vec_t vecs[7];
    edge_t     held, cur;
    int        xfers, stall;
    bit        seen, dn, vl;

    initial begin
        vecs[0] = '{1,  3, 0, 0, 0, 3, 1,  4, -1};
        vecs[1] = '{0,  0, 0, 0, 0, 0, -1, 2, -1};
        vecs[2] = '{4,  0, 1, 2, 4, 5, 3,  8,  3};
        vecs[3] = '{1,  9, 0, 0, 0, 8, 1,  9, -1};
        vecs[4] = '{2,  2, 3, 0, 0, 4, 1,  5, -1};
        vecs[5] = '{20, 3, 0, 0, 0, 3, 1, 19, -1};
        vecs[6] = '{3, 15, 2, 1, 0, 9, 1, 11,  5};

        rst_in = 1'b0;
        start_in = 1'b0;
        eif.edge_ready_in = 1'b0;
        set_pattern(vecs[0]);
`ifdef EDGE_BBOX_CULL_EN
        query_min_x_in = -16'sd32768;
        query_max_x_in = 16'sd32767;
        query_min_y_in = -16'sd32768;
        query_max_y_in = 16'sd32767;
`endif
        #2;
        check("rst_valid", eif.edge_valid_out, 0);
        check("rst_busy", busy_out, 0);
        check("rst_done", done_out, 0);
        check("rst_x0", eif.edge_x0_out, 0);
        check("rst_y0", eif.edge_y0_out, 0);
        check("rst_x1", eif.edge_x1_out, 0);
        check("rst_y1", eif.edge_y1_out, 0);
        check("rst_idx", eif.edge_obstacle_idx_out, 0);
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;

        for (int t = 0; t < 7; t++) begin
            set_pattern(vecs[t]);
            build_expected(vecs[t].num);
            run_scan($sformatf("vec%0d", t), vecs[t].exp_edges, vecs[t].exp_first,
                     vecs[t].exp_done, vecs[t].poke);
        end

        load_triangle();
        run_scan("tri", 3, 1, 4, -1);

        // Backpressure: hold the second triangle edge for five cycles.
        load_triangle();
        eif.edge_ready_in = 1'b1;
        pulse_start();
        xfers = 0; stall = 0; seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge clk_in);
            if (done_out) begin
                seen = 1'b1;
            end else if (eif.edge_valid_out) begin
                cur = dut_edge();
                if (xfers == 1 && stall < 5) begin
                    if (stall == 0) held = cur;
                    else check_edge($sformatf("bp_hold%0d", stall), cur, held);
                    stall++;
                    eif.edge_ready_in = 1'b0;
                end else begin
                    if (xfers < 3) check_edge($sformatf("bp_edge%0d", xfers), cur, exp_q[xfers]);
                    xfers++;
                    eif.edge_ready_in = 1'b1;
                end
            end
        end
        eif.edge_ready_in = 1'b1;
        check("bp_done_seen", seen, 1);
        check("bp_stall_cycles", stall, 5);
        check("bp_transfers", xfers, 3);

        // Asynchronous reset while the second edge is on the bus.
        load_triangle();
        pulse_start();
        @(negedge clk_in);
        @(negedge clk_in);
        @(negedge clk_in);
        check("mid_pre_valid", eif.edge_valid_out, 1);
        check("mid_pre_x0", eif.edge_x0_out, 10);
        rst_in = 1'b0;
        #1;
        check("mid_rst_valid", eif.edge_valid_out, 0);
        check("mid_rst_busy", busy_out, 0);
        check("mid_rst_done", done_out, 0);
        check("mid_rst_x0", eif.edge_x0_out, 0);
        @(negedge clk_in);
        rst_in = 1'b1;
        dn = 1'b0; vl = 1'b0;
        repeat (6) begin
            @(negedge clk_in);
            dn |= done_out;
            vl |= eif.edge_valid_out;
        end
        check("mid_no_done", dn, 0);
        check("mid_no_valid", vl, 0);
        run_scan("restart", 3, 1, 4, -1);

`ifdef EDGE_BBOX_CULL_EN
        for (int i = 0; i < MAX_OBSTACLES_ON_SCREEN; i++) obstacles_num_sides_in[i] = '0;
        obstacles_in[0][0] = pack_v(0, 0);
        obstacles_in[0][1] = pack_v(25, 0);
        obstacles_in[0][2] = pack_v(25, 25);
        obstacles_in[0][3] = pack_v(0, 25);
        obstacles_num_sides_in[0] = 4'd4;
        num_obstacles_in = 5'd1;
        query_min_x_in = 16'sd20;
        query_max_x_in = 16'sd30;
        query_min_y_in = 16'sd0;
        query_max_y_in = 16'sd5;
        exp_q.delete();
        exp_q.push_back(mk_edge(0, 0, 25, 0, 0));
        exp_q.push_back(mk_edge(25, 0, 25, 25, 0));
        run_scan("cull", 2, 1, 5, -1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
